// File: rtl/sipo_deserializer.sv
// ---------------------------------------------------------------------------
// sipo_deserializer
//
// Purpose:
//   Receive end of a bit-serial link. Collects one frame of serial bits,
//   reassembles the parallel word and offers it on a valid/ready output
//   through a one-deep buffer. Reception goes on while a word waits in the
//   buffer.
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   LSB_FIRST  1: first received bit lands in out_word[0]
//              0: first received bit lands in out_word[WIDTH-1]
//
// Optional feature (compile-time macro SIPO_PARITY_EN):
//   Defined:   each frame is WIDTH data bits followed by one even-parity bit.
//              The parity bit is checked but not stored. parity_err is loaded
//              together with out_word.
//   Undefined: a frame is WIDTH bits and parity_err is constant 0.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   in_bit      in   serial data bit
//   in_valid    in   in_bit is sampled on this edge
//   out_ready   in   consumer accepts out_word on this edge
//   out_word    out  last completed word (WIDTH bits)
//   out_valid   out  out_word holds an unconsumed word; this is also the
//                    buffer state bit (0 = EMPTY, 1 = FULL)
//   overrun     out  sticky: a completed word was dropped (cleared by reset)
//   bit_cnt     out  bits accepted in the current frame
//   parity_err  out  parity status of out_word
//
// Output handshake: a word moves to the consumer on every rising edge where
// out_valid=1 and out_ready=1. out_valid never depends on out_ready in the
// same cycle, and out_word is stable while out_valid=1 and out_ready=0.
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module sipo_deserializer #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_bit,
    input  logic                       in_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_word,
    output logic                       out_valid,
    output logic                       overrun,
    output logic [$clog2(WIDTH):0]     bit_cnt,
    output logic                       parity_err
);

    localparam int CW = $clog2(WIDTH) + 1;

`ifdef SIPO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Output buffer state. The encoding makes the state bit identical to
    // out_valid, so the state is visible on that port.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e        state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [WIDTH-1:0]  word_q,  word_d;
    logic              ovr_q,   ovr_d;
    logic              perr_q,  perr_d;

    // Combinational helpers
    logic              frame_done;
    logic              data_phase;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  done_word;
    logic              done_perr;

    // -----------------------------------------------------------------------
    // Serial side: shift register, bit counter, completed-word forwarding
    // -----------------------------------------------------------------------
    always_comb begin
        frame_done = in_valid && (cnt_q == LAST_IDX);

        if (LSB_FIRST) begin
            shifted = {in_bit, shreg_q[WIDTH-1:1]};
        end else begin
            shifted = {shreg_q[WIDTH-2:0], in_bit};
        end

`ifdef SIPO_PARITY_EN
        // The last bit of a frame is the parity bit: it never enters the
        // shift register, which already holds all WIDTH data bits by then.
        data_phase = (cnt_q != LAST_IDX);
        done_word  = shreg_q;
        // Even parity: XOR over data bits and parity bit must be 0.
        done_perr  = (^shreg_q) ^ in_bit;
`else
        // Every bit is a data bit; the completing bit is forwarded through
        // the shifted value instead of waiting for it to reach shreg_q.
        data_phase = 1'b1;
        done_word  = shifted;
        done_perr  = 1'b0;
`endif
    end

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        if (in_valid) begin
            if (data_phase) begin
                shreg_d = shifted;
            end
            if (frame_done) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer FSM: next state and buffer contents
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ovr_d   = ovr_q;
        perr_d  = perr_q;

        case (state_q)
            BUF_EMPTY: begin
                // out_ready while empty has nothing to consume.
                if (frame_done) begin
                    word_d  = done_word;
                    perr_d  = done_perr;
                    state_d = BUF_FULL;
                end
            end

            BUF_FULL: begin
                if (frame_done) begin
                    if (out_ready) begin
                        // Old word leaves and the new one takes its slot on
                        // the same edge, so nothing is lost.
                        word_d  = done_word;
                        perr_d  = done_perr;
                        state_d = BUF_FULL;
                    end else begin
                        // Buffer still occupied: the new word is dropped and
                        // the held word and its parity status stay intact.
                        ovr_d = 1'b1;
                    end
                end else if (out_ready) begin
                    // word_q is left stale; only out_valid drops.
                    state_d = BUF_EMPTY;
                end
            end

            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
            shreg_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all registered)
    // -----------------------------------------------------------------------
    assign out_word   = word_q;
    assign out_valid  = (state_q == BUF_FULL);
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer. Two instances share clock, reset,
// in_valid and out_ready: dut_l (LSB first) and dut_m (MSB first, own in_bit).
// Build with +define+SIPO_PARITY_EN to exercise the parity frames.
module tb_sipo_deserializer;

    localparam int W  = 32;
    localparam int CW = $clog2(W) + 1;
`ifdef SIPO_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic in_bit = 1'b0, in_bit2 = 1'b0, in_valid = 1'b0, out_ready = 1'b0;

    logic [W-1:0]  l_word, m_word;
    logic          l_valid, m_valid, l_ovr, m_ovr, l_perr, m_perr;
    logic [CW-1:0] l_cnt, m_cnt;

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .out_ready(out_ready), .out_word(l_word), .out_valid(l_valid),
        .overrun(l_ovr), .bit_cnt(l_cnt), .parity_err(l_perr)
    );

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .in_bit(in_bit2), .in_valid(in_valid),
        .out_ready(out_ready), .out_word(m_word), .out_valid(m_valid),
        .overrun(m_ovr), .bit_cnt(m_cnt), .parity_err(m_perr)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops the next expected LSB-first word and compares it with dut_l.
    task automatic check_word(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed %0h expected <empty queue>", tag, l_word);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(l_word), 64'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive inputs, let one rising edge pass, settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic idle(input logic rdy);
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_bit2   = 1'b0;
        out_ready = rdy;
        step();
        out_ready = 1'b0;
    endtask

    // Sends w LSB first to dut_l and w2 MSB first to dut_m as one frame each.
    // out_ready is 0 except on the completing edge, where it is rdy_last.
    // gaps inserts an idle cycle after every bit. par_bad flips the parity bit.
    task automatic send_word(input logic [W-1:0] w, input logic [W-1:0] w2,
                             input bit gaps, input logic rdy_last, input bit par_bad);
        for (int i = 0; i < F; i++) begin
            in_valid = 1'b1;
            if (i < W) begin
                in_bit  = w[i];
                in_bit2 = w2[W-1-i];
            end else begin
                in_bit  = (^w) ^ par_bad;
                in_bit2 = ^w2;
            end
            out_ready = (i == F - 1) ? rdy_last : 1'b0;
            step();
            out_ready = 1'b0;
            if (gaps && i < F - 1) begin
                in_valid = 1'b0;
                in_bit   = ~in_bit;
                step();
                if (i == 4) check("t4_cnt_hold_gap", 64'(l_cnt), 64'd5);
            end
        end
        in_valid = 1'b0;
    endtask

    // Watchdog: the sequence is fixed-length, this only guards against a hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        do_reset();
        check("reset_valid", 64'(l_valid), 64'd0);
        check("reset_word",  64'(l_word),  64'd0);
        check("reset_cnt",   64'(l_cnt),   64'd0);
        check("reset_ovr",   64'(l_ovr),   64'd0);
        check("reset_perr",  64'(l_perr),  64'd0);

        // 1: single word, consumer not ready
        exp_q.push_back(32'h0000007B);
        send_word(32'd123, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t1_valid", 64'(l_valid), 64'd1);
        check_word("t1_word");
        check("t1_cnt",   64'(l_cnt),   64'd0);
        check("t1_ovr",   64'(l_ovr),   64'd0);
        check("t1_perr",  64'(l_perr),  64'd0);

        // 2: back-to-back words, ready on the second completion edge
        do_reset();
        send_word(32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'h00000001);
        send_word(32'h00000001, 32'h0, 1'b0, 1'b1, 1'b0);
        check_word("t2_word");
        check("t2_valid", 64'(l_valid), 64'd1);
        check("t2_ovr",   64'(l_ovr),   64'd0);
        idle(1'b1);
        check("t2_consumed_valid", 64'(l_valid), 64'd0);
        check("t2_stale_word",     64'(l_word),  64'h00000001);
        idle(1'b1);
        check("t2_empty_ready", 64'(l_valid), 64'd0);

        // 3: overrun, sticky until reset
        do_reset();
        send_word(32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0);
        send_word(32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t3_word_kept", 64'(l_word),  64'hFFFFFFFF);
        check("t3_ovr",       64'(l_ovr),   64'd1);
        check("t3_valid",     64'(l_valid), 64'd1);
        idle(1'b1);
        idle(1'b0);
        check("t3_ovr_sticky", 64'(l_ovr),   64'd1);
        check("t3_valid_gone", 64'(l_valid), 64'd0);
        do_reset();
        check("t3_ovr_reset",  64'(l_ovr),   64'd0);

        // 4: in_valid toggling every cycle
        exp_q.push_back(32'hA5A5A5A5);
        send_word(32'hA5A5A5A5, 32'h0, 1'b1, 1'b0, 1'b0);
        check_word("t4_word");
        check("t4_valid", 64'(l_valid), 64'd1);

        // 5: reset mid-frame discards partial bits
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("t5_cnt_partial",   64'(l_cnt),   64'd10);
        check("t5_valid_partial", 64'(l_valid), 64'd0);
        do_reset();
        check("t5_cnt_after_rst",   64'(l_cnt),   64'd0);
        check("t5_valid_after_rst", 64'(l_valid), 64'd0);
        exp_q.push_back(32'h12345678);
        send_word(32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0);
        check_word("t5_word");

        // 6: MSB-first instance alongside an LSB-first word
        do_reset();
        exp_q.push_back(32'h0000F00D);
        send_word(32'h0000F00D, 32'h80000001, 1'b0, 1'b0, 1'b0);
        check_word("t6_lsb_word");
        check("t6_msb_word",  64'(m_word),  64'h80000001);
        check("t6_msb_valid", 64'(m_valid), 64'd1);
        check("t6_msb_cnt",   64'(m_cnt),   64'd0);

`ifdef SIPO_PARITY_EN
        // 6 (parity): 0x3 has even weight, so parity bit 0 is correct
        do_reset();
        exp_q.push_back(32'h00000003);
        send_word(32'h00000003, 32'h0, 1'b0, 1'b0, 1'b0);
        check_word("t6_par_word");
        check("t6_par_ok", 64'(l_perr), 64'd0);
        idle(1'b1);
        exp_q.push_back(32'h00000003);
        send_word(32'h00000003, 32'h0, 1'b0, 1'b0, 1'b1);
        check_word("t6_par_word_bad");
        check("t6_par_err", 64'(l_perr), 64'd1);
        // Dropped word must not disturb the held parity status.
        send_word(32'h00000003, 32'h0, 1'b0, 1'b0, 1'b0);
        check("t6_par_hold_on_drop", 64'(l_perr), 64'd1);
        check("t6_par_ovr",          64'(l_ovr),  64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
